instr_fetch: RTL

Instruction fetch and next-PC unit that produces the instruction stream consumed by the control decoder. It consumes the decoder's Jump, Branch and Equal outputs plus the ALU Zero flag to redirect the PC. It owns the PC register and drives a request/ready instruction-memory port. It presents each fetched instruction to the core with a valid/accept handshake.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/next_pc_calc.sv | 40 ++++
 rtl/instr_fetch.sv | 84 ++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch path: fetch FSM states,
// instruction width and the opcode values the control decoder recognises.
package mips_pkg;

   localparam int INSTR_W = 32;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/ready port: the fetch unit is the master,
// the memory (or its model) is the slave.
interface instr_fetch_if #(
   parameter int ADDR_W = 32
);
   import mips_pkg::*;

   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ready;
   logic [INSTR_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );

endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump target, taken beq/bne target, or
// fall-through. All arithmetic is modulo 2^ADDR_W.
module next_pc_calc
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]  pc_plus4,
   input  logic [INSTR_W-1:0] ins,
   input  logic               jump,
   input  logic               branch,
   input  logic               equal,
   input  logic               zero,
   output logic [ADDR_W-1:0]  next_pc
);

   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] branch_offset;
   logic              branch_taken;

   // The opcode field is decoded upstream; only the immediates matter here.
   logic unused_opcode;
   assign unused_opcode = ^ins[31:26];

   assign jump_target   = {pc_plus4[ADDR_W-1:28], ins[25:0], 2'b00};
   assign branch_offset = {{(ADDR_W-18){ins[15]}}, ins[15:0], 2'b00};
   // equal=1 selects beq (taken on zero), equal=0 selects bne (taken on !zero).
   assign branch_taken  = branch && (zero == equal);

   always_comb begin
      if (jump) begin
         next_pc = jump_target;
      end else if (branch_taken) begin
         next_pc = pc_plus4 + branch_offset;
      end else begin
         next_pc = pc_plus4;
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, fetches over a request/ready port and
// holds each instruction for the core until it is accepted.
module instr_fetch
   import mips_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   instr_fetch_if.master      imem,
   output logic               ins_valid,
   output logic [INSTR_W-1:0] ins,
   output logic [5:0]         opcode,
   output logic [ADDR_W-1:0]  pc_plus4,
   input  logic               ins_accept,
   input  logic               jump,
   input  logic               branch,
   input  logic               equal,
   input  logic               zero
);

   fetch_state_e       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [INSTR_W-1:0] ins_q, ins_d;
   logic [ADDR_W-1:0]  next_pc;

   assign pc_plus4       = pc_q + ADDR_W'(4);
   assign ins            = ins_q;
   assign opcode         = ins_q[31:26];
   assign ins_valid      = (state_q == HOLD);
   // Request is decoded from state so an async reset drops it immediately.
   assign imem.imem_req  = (state_q == FETCH);
   assign imem.imem_addr = pc_q;

   next_pc_calc #(
      .ADDR_W (ADDR_W)
   ) u_next_pc_calc (
      .pc_plus4 (pc_plus4),
      .ins      (ins_q),
      .jump     (jump),
      .branch   (branch),
      .equal    (equal),
      .zero     (zero),
      .next_pc  (next_pc)
   );

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      unique case (state_q)
         BOOT: state_d = FETCH;
         FETCH: begin
            if (imem.imem_ready) begin
               ins_d   = imem.imem_rdata;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (ins_accept) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         ins_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
      end
   end

endmodule
